// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch-stage types and constants.
package cpu_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  typedef enum logic [1:0] {FETCH = 2'd0, VALID = 2'd1, ERR = 2'd2} fetch_state_e;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts consecutive un-acked fetch cycles and flags the TIMEOUT-th one.
module fetch_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count_en,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // Fires combinationally in the cycle that would be the TIMEOUT-th wait, so a same-cycle ack suppresses it.
  assign expired = count_en && (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d = clear ? '0 : count_en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and fetch sequencer with valid/ready hand-off to decode.
module pc_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  pc_next_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               misalign_o,
  output logic               timeout_o
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic misalign_q, misalign_d, timeout_q, timeout_d, in_fetch, expired;
  assign in_fetch = state_q == FETCH;
  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .count_en (in_fetch && !imem_ack_i),
    .clear    (!in_fetch || imem_ack_i),
    .expired  (expired)
  );
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + ADDR_W'(PC_STEP);
  // Reset leaves the state in FETCH, so the request is masked while rst_i is held.
  assign imem_req_o    = in_fetch && !rst_i;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = state_q == VALID;
  assign misalign_o    = misalign_q;
  assign timeout_o     = timeout_q;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    if (in_fetch && imem_ack_i) begin
      instr_d = imem_rdata_i;
      state_d = VALID;
    end else if (expired) begin
      timeout_d = 1'b1;
      state_d   = ERR;
    end else if (state_q == VALID && instr_ready_i) begin
      pc_d       = pc_next_i;
      misalign_d = (pc_next_i[1:0] & ALIGN_MASK) != 2'b00;
      state_d    = misalign_d ? ERR : FETCH;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for the PC register / fetch sequencer.
module tb_pc_fetch_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic imem_ack_i = 1'b0;
  logic instr_ready_i = 1'b0;
  logic [31:0] pc_next_i = '0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] pc_o, pc_plus4_o, imem_addr_o, instr_o;
  logic imem_req_o, instr_valid_o, misalign_o, timeout_o;

  typedef struct {logic [31:0] addr; logic [31:0] instr;} exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  logic vprev = 1'b0;

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_next_i(pc_next_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Each rising edge of instr_valid_o consumes one scoreboard entry.
  always @(negedge clk_i) begin
    if (instr_valid_o && !vprev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: valid with instr=%h pc=%h but nothing expected", instr_o, pc_o);
      end else begin
        e = sb.pop_front();
        if (instr_o !== e.instr || pc_o !== e.addr) begin
          errors++;
          $display("FAIL sb_entry: got instr=%h pc=%h, expected instr=%h pc=%h", instr_o, pc_o, e.instr, e.addr);
        end
      end
    end
    vprev = instr_valid_o;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_ack(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{addr: a, instr: d});
    imem_ack_i = 1'b1;
    imem_rdata_i = d;
    tick();
    imem_ack_i = 1'b0;
    imem_rdata_i = 32'h0;
  endtask

  task automatic accept(input logic [31:0] nxt);
    instr_ready_i = 1'b1;
    pc_next_i = nxt;
    tick();
    instr_ready_i = 1'b0;
    pc_next_i = 32'h0000_0101;
  endtask

  task automatic test_reset;
    #2;
    checks += 6;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", pc_o); end
    if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr_o); end
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid_o); end
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
    if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign_o); end
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout_o); end
    tick();
    rst_i = 1'b0;
    #1;
    checks += 3;
    if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rel_req: got %b expected 1", imem_req_o); end
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rel_addr: got %h expected 0", imem_addr_o); end
    if (pc_plus4_o !== 32'h4) begin errors++; $display("FAIL rel_pc4: got %h expected 4", pc_plus4_o); end
  endtask

  task automatic test_first_fetch;
    mem_ack(32'h0, 32'h2008_0005);
    checks += 3;
    if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b expected 1", instr_valid_o); end
    if (instr_o !== 32'h2008_0005) begin errors++; $display("FAIL ff_instr: got %h expected 20080005", instr_o); end
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL ff_req: got %b expected 0", imem_req_o); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      imem_ack_i = (i == 2);
      imem_rdata_i = 32'hDEAD_BEEF;
      tick();
      checks += 3;
      if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid_o); end
      if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req_o); end
      if (instr_o !== 32'h2008_0005) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected 20080005", i, instr_o); end
    end
    imem_ack_i = 1'b0;
    accept(32'h4);
    checks += 3;
    if (pc_o !== 32'h4) begin errors++; $display("FAIL stall_pc: got %h expected 4", pc_o); end
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL stall_req_after: got req=%b addr=%h expected req=1 addr=4", imem_req_o, imem_addr_o); end
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid_after: got %b expected 0", instr_valid_o); end
  endtask

  task automatic test_jump;
    mem_ack(32'h4, 32'h0800_0010);
    accept(32'h40);
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin errors++; $display("FAIL jmp_req[%0d]: got req=%b addr=%h expected req=1 addr=40", i, imem_req_o, imem_addr_o); end
      if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL jmp_valid_early[%0d]: got %b expected 0", i, instr_valid_o); end
      if (i < 3) tick();
    end
    mem_ack(32'h40, 32'h2009_0007);
    checks += 2;
    if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL jmp_valid: got %b expected 1", instr_valid_o); end
    if (pc_plus4_o !== 32'h44) begin errors++; $display("FAIL jmp_pc4: got %h expected 44", pc_plus4_o); end
  endtask

  task automatic test_misalign;
    accept(32'h42);
    checks += 4;
    if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", misalign_o); end
    if (pc_o !== 32'h42) begin errors++; $display("FAIL mis_pc: got %h expected 42", pc_o); end
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL mis_handshake: got req=%b valid=%b expected 0 0", imem_req_o, instr_valid_o); end
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL mis_timeout: got %b expected 0", timeout_o); end
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'hCAFE_0000;
    instr_ready_i = 1'b1;
    pc_next_i = 32'h100;
    repeat (3) tick();
    imem_ack_i = 1'b0;
    instr_ready_i = 1'b0;
    checks += 2;
    if (pc_o !== 32'h42 || instr_o !== 32'h2009_0007) begin errors++; $display("FAIL err_frozen: got pc=%h instr=%h expected pc=42 instr=20090007", pc_o, instr_o); end
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || misalign_o !== 1'b1) begin errors++; $display("FAIL err_outputs: got req=%b valid=%b mis=%b expected 0 0 1", imem_req_o, instr_valid_o, misalign_o); end
    #2 rst_i = 1'b1;
    #1;
    checks += 2;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL mis_rst_pc: got %h expected 0", pc_o); end
    if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_rst_flag: got %b expected 0", misalign_o); end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_timeout;
    repeat (14) tick();
    checks += 2;
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", timeout_o); end
    if (imem_req_o !== 1'b1) begin errors++; $display("FAIL to_req14: got %b expected 1", imem_req_o); end
    tick();
    checks += 3;
    if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout_o); end
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL to_handshake: got req=%b valid=%b expected 0 0", imem_req_o, instr_valid_o); end
    if (misalign_o !== 1'b0) begin errors++; $display("FAIL to_misalign: got %b expected 0", misalign_o); end
    #2 rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (14) tick();
    mem_ack(32'h0, 32'h1234_5678);
    checks += 2;
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_edge_flag: got %b expected 0", timeout_o); end
    if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL to_edge_valid: got %b expected 1", instr_valid_o); end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 4; i++) begin
      accept(32'(4 * i));
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * i)) begin errors++; $display("FAIL b2b_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req_o, imem_addr_o, 32'(4 * i)); end
      mem_ack(32'(4 * i), 32'h00A0_0000 + 32'(i));
      checks++;
      if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, instr_valid_o); end
    end
  endtask

  task automatic test_wrap;
    accept(32'hFFFF_FFFC);
    checks += 2;
    if (pc_plus4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 0", pc_plus4_o); end
    if (misalign_o !== 1'b0 || imem_req_o !== 1'b1) begin errors++; $display("FAIL wrap_state: got mis=%b req=%b expected 0 1", misalign_o, imem_req_o); end
    mem_ack(32'hFFFF_FFFC, 32'h0000_0013);
  endtask

  task automatic test_async_reset;
    accept(32'h80);
    tick();
    #2 rst_i = 1'b1;
    #1;
    checks += 3;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL ar_req: got %b expected 0", imem_req_o); end
    if (pc_o !== 32'h0) begin errors++; $display("FAIL ar_pc: got %h expected 0", pc_o); end
    if (instr_o !== 32'h0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL ar_instr: got instr=%h valid=%b expected 0 0", instr_o, instr_valid_o); end
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL ar_rel: got req=%b addr=%h expected req=1 addr=0", imem_req_o, imem_addr_o); end
    mem_ack(32'h0, 32'h2008_0005);
    imem_ack_i = 1'b1;
    imem_rdata_i = 32'hFFFF_FFFF;
    tick();
    imem_ack_i = 1'b0;
    checks++;
    if (instr_o !== 32'h2008_0005 || instr_valid_o !== 1'b1) begin errors++; $display("FAIL ar_spurious: got instr=%h valid=%b expected 20080005 1", instr_o, instr_valid_o); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_jump();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    tick();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending entries expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
